// File: rtl/fbcpu_run_ctrl_pkg.sv
// Shared types and constants for the fb_cpu run controller.
package fbcpu_ctrl_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 6;
    localparam int unsigned DEF_DATA_WIDTH    = 10;
    localparam int unsigned DEF_CNT_WIDTH     = 16;

    // Kept for a future opcode-based halt detector; PC-stall detection is used today.
    localparam logic [3:0] OP_HALT = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_READ,
        ST_CAPTURE,
        ST_DONE
    } run_state_t;

endpackage

// File: rtl/fbcpu_run_ctrl_ram_port_mux.sv
// Combinational owner select for the single blram port: controller/host side or CPU bus.
module ram_port_mux
    import fbcpu_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     i_sel_cpu,
    input  logic [ADDRESS_WIDTH-1:0] i_ctl_addr,
    input  logic                     i_ctl_we,
    input  logic [DATA_WIDTH-1:0]    i_ctl_wdata,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_addr,
    input  logic                     i_cpu_we,
    input  logic [DATA_WIDTH-1:0]    i_cpu_wdata,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic                     o_we,
    output logic [DATA_WIDTH-1:0]    o_wdata
);

    always_comb begin
        o_addr  = i_ctl_addr;
        o_we    = i_ctl_we;
        o_wdata = i_ctl_wdata;
        if (i_sel_cpu) begin
            o_addr  = i_cpu_addr;
            o_we    = i_cpu_we;
            o_wdata = i_cpu_wdata;
        end
    end

endmodule

// File: rtl/fbcpu_run_ctrl.sv
// Run controller: host program load, CPU release, halt/timeout detection and result read-back.
module fbcpu_run_ctrl
    import fbcpu_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int MAX_CYCLES    = 1000,
    parameter int HALT_WINDOW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] result_addr,
    output logic                     cpu_rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_pc,
    input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
    input  logic                     cpu_we,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_we,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     halted,
    output logic                     timeout,
    output logic                     result_valid,
    output logic [DATA_WIDTH-1:0]    result_data
);

    run_state_t r_state;
    run_state_t w_next;

    logic [CNT_WIDTH-1:0]     r_cycle_cnt;
    logic [CNT_WIDTH-1:0]     r_stall_cnt;
    logic [ADDRESS_WIDTH-1:0] r_prev_pc;
    logic                     r_cpu_rst;
    logic                     r_load_ready;
    logic                     r_halted;
    logic                     r_timeout;
    logic [DATA_WIDTH-1:0]    r_result_data;

    logic                     w_accept;
    logic                     w_halt_hit;
    logic                     w_time_hit;
    logic                     w_set_halted;
    logic                     w_set_timeout;
    logic [ADDRESS_WIDTH-1:0] w_ctl_addr;
    logic                     w_ctl_we;
    logic [DATA_WIDTH-1:0]    w_ctl_wdata;

    assign w_accept   = load_valid && r_load_ready;
    assign w_halt_hit = (r_stall_cnt == CNT_WIDTH'(HALT_WINDOW - 1));
    assign w_time_hit = (r_cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Halt is tested before timeout so a coincident budget expiry reports as a halt.
    always_comb begin
        w_next        = r_state;
        w_set_halted  = 1'b0;
        w_set_timeout = 1'b0;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (start) w_next = ST_RUN;
                ST_RUN: begin
                    if (w_halt_hit) begin
                        w_next       = ST_READ;
                        w_set_halted = 1'b1;
                    end else if (w_time_hit) begin
                        w_next        = ST_READ;
                        w_set_timeout = 1'b1;
                    end
                end
                ST_READ:    w_next = ST_CAPTURE;
                ST_CAPTURE: w_next = ST_DONE;
                ST_DONE:    if (start) w_next = ST_RUN;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ctl_addr  = '0;
        w_ctl_we    = 1'b0;
        w_ctl_wdata = '0;
        if (r_state == ST_READ) begin
            w_ctl_addr = result_addr;
        end else if (w_accept) begin
            w_ctl_addr  = load_addr;
            w_ctl_we    = 1'b1;
            w_ctl_wdata = load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rst     <= 1'b1;
            r_load_ready  <= 1'b0;
            r_cycle_cnt   <= '0;
            r_stall_cnt   <= '0;
            r_prev_pc     <= '0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_result_data <= '0;
        end else begin
            r_cpu_rst    <= (w_next != ST_RUN);
            r_load_ready <= (w_next == ST_IDLE);
            r_prev_pc    <= cpu_pc;
            if (w_next == ST_RUN && r_state != ST_RUN) begin
                r_cycle_cnt <= '0;
                r_stall_cnt <= '0;
                r_halted    <= 1'b0;
                r_timeout   <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
                r_stall_cnt <= (cpu_pc == r_prev_pc) ? r_stall_cnt + 1'b1 : '0;
            end
            if (w_next == ST_IDLE) begin
                r_halted  <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_set_halted) begin
                r_halted <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
            if (r_state == ST_CAPTURE) begin
                r_result_data <= ram_rdata;
            end
        end
    end

    ram_port_mux #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_mux (
        .i_sel_cpu  (r_state == ST_RUN),
        .i_ctl_addr (w_ctl_addr),
        .i_ctl_we   (w_ctl_we),
        .i_ctl_wdata(w_ctl_wdata),
        .i_cpu_addr (cpu_mar),
        .i_cpu_we   (cpu_we),
        .i_cpu_wdata(cpu_wdata),
        .o_addr     (ram_addr),
        .o_we       (ram_we),
        .o_wdata    (ram_wdata)
    );

    assign cpu_rst      = r_cpu_rst;
    assign load_ready   = r_load_ready;
    assign busy         = (r_state == ST_RUN);
    assign done         = (r_state == ST_DONE);
    assign result_valid = (r_state == ST_DONE);
    assign halted       = r_halted;
    assign timeout      = r_timeout;
    assign result_data  = r_result_data;

endmodule
